// File: rtl/adder_scoreboard_if.sv
// Operand/result tap and run control seen by the adder scoreboard.
// The master drives the pairs and results, the scoreboard observes them.
interface adder_scoreboard_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 32
);
  logic              start_i;
  logic [CNT_W-1:0]  total_i;
  logic              in_valid_i;
  logic [DATA_W-1:0] a_i;
  logic [DATA_W-1:0] b_i;
  logic [DATA_W-1:0] res_i;

  modport master (output start_i, total_i, in_valid_i, a_i, b_i, res_i);
  modport slave  (input  start_i, total_i, in_valid_i, a_i, b_i, res_i);
endinterface

// File: rtl/adder_scoreboard.sv
// Scoreboard for the 8-bit adder: predicts each sum and delays it by LATENCY.
// It then checks the prediction against res_i and reports a run verdict.
module adder_scoreboard #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned CNT_W   = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  adder_scoreboard_if.slave bus,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic              extra_o,
  output logic [CNT_W-1:0]  checked_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic [CNT_W-1:0]  first_err_idx_o,
  output logic [DATA_W-1:0] first_err_exp_o,
  output logic [DATA_W-1:0] first_err_got_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Every stage except the last; the last one is compared this cycle.
  localparam logic [LATENCY-1:0] HEAD_MASK = LATENCY'((1 << (LATENCY - 1)) - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  total_q, total_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  checked_q, checked_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic [CNT_W-1:0]  fidx_q, fidx_d;
  logic [DATA_W-1:0] fexp_q, fexp_d;
  logic [DATA_W-1:0] fgot_q, fgot_d;
  logic              extra_q, extra_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;

  logic [LATENCY-1:0] vld_q;
  logic [DATA_W-1:0]  exp_q [LATENCY];
  logic [CNT_W-1:0]   idx_q [LATENCY];

  logic              accept_c;
  logic              start_ok_c;
  logic              inflight_c;
  logic              cmp_vld_c;
  logic              mismatch_c;
  logic [DATA_W-1:0] sum_c;

  assign sum_c      = bus.a_i + bus.b_i;
  assign accept_c   = (state_q == ST_RUN) && bus.in_valid_i && (issued_q < total_q);
  assign start_ok_c = bus.start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign inflight_c = |(vld_q & HEAD_MASK);
  assign cmp_vld_c  = vld_q[LATENCY-1];
  assign mismatch_c = cmp_vld_c && (exp_q[LATENCY-1] != bus.res_i);

  // Expected-sum delay line: valids are reset, payload just follows them.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vld_q <= '0;
    end else begin
      vld_q <= LATENCY'({vld_q, accept_c});
    end
  end

  always_ff @(posedge clk_i) begin
    exp_q[0] <= sum_c;
    idx_q[0] <= issued_q;
    for (int i = 1; i < int'(LATENCY); i++) begin
      exp_q[i] <= exp_q[i-1];
      idx_q[i] <= idx_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      total_q   <= '0;
      issued_q  <= '0;
      checked_q <= '0;
      err_q     <= '0;
      fidx_q    <= '0;
      fexp_q    <= '0;
      fgot_q    <= '0;
      extra_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      total_q   <= total_d;
      issued_q  <= issued_d;
      checked_q <= checked_d;
      err_q     <= err_d;
      fidx_q    <= fidx_d;
      fexp_q    <= fexp_d;
      fgot_q    <= fgot_d;
      extra_q   <= extra_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    total_d   = total_q;
    issued_d  = issued_q;
    checked_d = checked_q;
    err_d     = err_q;
    fidx_d    = fidx_q;
    fexp_d    = fexp_q;
    fgot_d    = fgot_q;
    extra_d   = extra_q;

    if (cmp_vld_c) begin
      checked_d = checked_q + CNT_W'(1);
      if (mismatch_c) begin
        if (err_q != '1) err_d = err_q + CNT_W'(1);
        if (err_q == '0) begin
          fidx_d = idx_q[LATENCY-1];
          fexp_d = exp_q[LATENCY-1];
          fgot_d = bus.res_i;
        end
      end
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok_c) begin
          total_d   = bus.total_i;
          issued_d  = '0;
          checked_d = '0;
          err_d     = '0;
          fidx_d    = '0;
          fexp_d    = '0;
          fgot_d    = '0;
          extra_d   = 1'b0;
          state_d   = (bus.total_i == '0) ? ST_DONE : ST_RUN;
        end else if ((state_q == ST_DONE) && bus.in_valid_i) begin
          extra_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (accept_c) begin
          issued_d = issued_q + CNT_W'(1);
          if (issued_d == total_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (bus.in_valid_i) extra_d = 1'b1;
        if (!inflight_c) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
    pass_d = done_d && (err_d == '0) && !extra_d;
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign pass_o          = pass_q;
  assign extra_o         = extra_q;
  assign checked_o       = checked_q;
  assign err_cnt_o       = err_q;
  assign first_err_idx_o = fidx_q;
  assign first_err_exp_o = fexp_q;
  assign first_err_got_o = fgot_q;

endmodule
